audio_sample_decimator: RTL and testbench

//  Upstream feeder for the PicoBlaze LED/interrupt stage. Takes signed 16-bit audio samples

---
 rtl/audio_sample_decimator_pkg.sv | 24 ++
 rtl/audio_sample_decimator_rise_edge_detect.sv | 28 ++
 rtl/audio_sample_decimator.sv | 160 ++++++++++++++++
 tb/tb_audio_sample_decimator.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_sample_decimator_pkg.sv
// Shared encodings and widths for the audio sample decimator.
// Holds the FSM state encoding, sample/output widths and a timer sizing helper.
package audio_sample_decimator_pkg;

    localparam int SAMPLE_W = 16;
    localparam int OUT_W    = 8;
    localparam int DROP_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PULSE   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_e;

    // One shared down-counter serves both the pulse and holdoff windows; it
    // only ever holds values up to (window length - 1).
    function automatic int tmr_width(input int pulse_cycles, input int holdoff_cycles);
        int m;
        m = (pulse_cycles > holdoff_cycles) ? pulse_cycles : holdoff_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/audio_sample_decimator_rise_edge_detect.sv
// Purpose: flags the first cycle a level input is seen high.
// Latency: rise is combinational from d against a one-cycle registered copy.
// Backpressure: none; the history flop updates every cycle regardless of consumers.
module rise_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic d_prev_q;
    logic d_prev_d;

    always_comb begin
        d_prev_d = d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_prev_q <= 1'b0;
        end else begin
            d_prev_q <= d_prev_d;
        end
    end

    assign rise = d & ~d_prev_q;

endmodule

// File: rtl/audio_sample_decimator.sv
// Purpose: averages blocks of 2**LOG2_DECIM samples and publishes the 8-bit mean with an interrupt pulse.
// Latency: outputs update the cycle after the edge that captures the block's last strobe rise.
// Backpressure: none upstream; blocks finishing while the pulse/holdoff window is open are counted as drops.
module audio_sample_decimator
    import audio_sample_decimator_pkg::*;
#(
    parameter int LOG2_DECIM     = 2,
    parameter int PULSE_CYCLES   = 4,
    parameter int HOLDOFF_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                sample_strobe,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic [OUT_W-1:0]    sample_out,
    output logic                interrupt_event,
    output logic [DROP_W-1:0]   dropped_count,
    output logic                busy
);

    localparam int ACC_W = SAMPLE_W + LOG2_DECIM;
    localparam int CNT_W = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam int TMR_W = tmr_width(PULSE_CYCLES, HOLDOFF_CYCLES);

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'((1 << LOG2_DECIM) - 1);
    localparam logic [TMR_W-1:0] PULSE_LOAD  = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLDOFF_LOAD = TMR_W'(HOLDOFF_CYCLES - 1);

    state_e                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [TMR_W-1:0]         tmr_q, tmr_d;
    logic [OUT_W-1:0]         out_q, out_d;
    logic                     irq_q, irq_d;
    logic [DROP_W-1:0]        drop_q, drop_d;
    logic                     busy_q, busy_d;

    logic                     stb_rise;
    logic signed [ACC_W-1:0]  sample_ext;
    logic signed [ACC_W-1:0]  sum_next;
    logic [OUT_W-1:0]         mean;
    logic                     take;
    logic                     blk_done;

    rise_edge_detect u_stb_edge (
        .clk   (clk),
        .reset (reset),
        .d     (sample_strobe),
        .rise  (stb_rise)
    );

    assign sample_ext = ACC_W'($signed(sample_in));
    assign sum_next   = acc_q + sample_ext;
    // Top 8 bits of the sum: arithmetic divide by 2**LOG2_DECIM, then drop 8 LSBs (floor).
    assign mean       = sum_next[SAMPLE_W-1+LOG2_DECIM -: OUT_W];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        tmr_d    = tmr_q;
        out_d    = out_q;
        irq_d    = irq_q;
        drop_d   = drop_q;
        busy_d   = busy_q;
        take     = enable && (state_q != ST_IDLE) && stb_rise;
        blk_done = take && (cnt_q == CNT_LAST);

        if (take) begin
            if (blk_done) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum_next;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (!enable) begin
            state_d = ST_IDLE;
            irq_d   = 1'b0;
            acc_d   = '0;
            cnt_d   = '0;
            tmr_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (blk_done) begin
                        out_d   = mean;
                        irq_d   = 1'b1;
                        tmr_d   = PULSE_LOAD;
                        state_d = ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (tmr_q == '0) begin
                        irq_d = 1'b0;
                        if (HOLDOFF_CYCLES == 0) begin
                            state_d = ST_RUN;
                        end else begin
                            tmr_d   = HOLDOFF_LOAD;
                            state_d = ST_HOLDOFF;
                        end
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (tmr_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Only a block finishing in RUN is published; anything else is a drop.
            if (blk_done && (state_q != ST_RUN) && (drop_q != '1)) begin
                drop_d = drop_q + DROP_W'(1);
            end
        end

        busy_d = (state_d == ST_PULSE) || (state_d == ST_HOLDOFF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            out_q   <= '0;
            irq_q   <= 1'b0;
            drop_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            out_q   <= out_d;
            irq_q   <= irq_d;
            drop_q  <= drop_d;
            busy_q  <= busy_d;
        end
    end

    assign sample_out      = out_q;
    assign interrupt_event = irq_q;
    assign dropped_count   = drop_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_audio_sample_decimator.sv
// Randomized and directed stimulus against a cycle-indexed reference model; a monitor
// pops expected publishes from a queue whenever interrupt_event rises.
module tb_audio_sample_decimator;

    localparam int L = 2;
    localparam int P = 4;
    localparam int H = 64;
    localparam int NBLK = 1 << L;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        sample_strobe;
    logic [15:0] sample_in;
    logic [7:0]  sample_out;
    logic        interrupt_event;
    logic [7:0]  dropped_count;
    logic        busy;

    audio_sample_decimator #(
        .LOG2_DECIM     (L),
        .PULSE_CYCLES   (P),
        .HOLDOFF_CYCLES (H)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .sample_strobe   (sample_strobe),
        .sample_in       (sample_in),
        .sample_out      (sample_out),
        .interrupt_event (interrupt_event),
        .dropped_count   (dropped_count),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         k;
        logic [7:0] mean;
    } exp_t;
    exp_t exp_q[$];

    int n_pass   = 0;
    int n_checks = 0;

    // Reference model state, indexed by absolute clock edge number.
    bit         model_en   = 1'b0;
    int         model_sum  = 0;
    int         model_n    = 0;
    int         next_ok    = 0;
    int         last_pub   = -1000;
    int         model_drop = 0;
    logic [7:0] last_mean  = 8'h00;
    bit         rst_phase  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    function automatic logic [7:0] floor_mean(input int s);
        int d;
        int q;
        d = 1 << (L + 8);
        q = s / d;
        if ((s % d != 0) && (s < 0)) q = q - 1;
        return q[7:0];
    endfunction

    // A block is publishable once the previous pulse plus holdoff window has fully elapsed.
    task automatic model_rise(input int k, input logic [15:0] v);
        logic [7:0] m;
        if (!model_en) return;
        model_sum += int'($signed(v));
        model_n++;
        if (model_n == NBLK) begin
            m = floor_mean(model_sum);
            model_sum = 0;
            model_n = 0;
            if (k >= next_ok) begin
                exp_q.push_back('{k: k, mean: m});
                last_pub  = k;
                last_mean = m;
                next_ok   = k + P + H + 1;
            end else if (model_drop < 255) begin
                model_drop++;
            end
        end
    endtask

    task automatic send(input logic [15:0] v, input int hold, input int gap);
        sample_in = v;
        sample_strobe = 1'b1;
        model_rise(cyc + 1, v);
        repeat (hold) @(posedge clk);
        #1;
        sample_strobe = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        repeat (P + H + 6) @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard.
    bit prev_irq = 1'b0;
    int hi_cnt   = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_phase || reset) begin
            prev_irq = 1'b0;
            hi_cnt   = 0;
        end else begin
            if (interrupt_event && !prev_irq) begin
                chk("pulse_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("pulse_cycle", cyc, e.k);
                    chk("sample_out", int'(sample_out), int'(e.mean));
                end
                hi_cnt = 1;
            end else if (interrupt_event) begin
                hi_cnt++;
            end else if (prev_irq) begin
                chk("pulse_width", hi_cnt, P);
            end
            chk("busy", int'(busy), int'((cyc >= last_pub) && (cyc <= last_pub + P + H - 1)));
            prev_irq = interrupt_event;
        end
    end

    initial begin
        bit seen;
        reset = 1'b1;
        enable = 1'b0;
        sample_strobe = 1'b0;
        sample_in = 16'h0000;
        #3;
        chk("reset_sample_out", int'(sample_out), 0);
        chk("reset_irq", int'(interrupt_event), 0);
        chk("reset_dropped", int'(dropped_count), 0);
        chk("reset_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b1;
        model_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed means: positive, negative, full-scale negative, long-held strobe.
        send(16'h1000, 1, 1); send(16'h2000, 1, 1); send(16'h3000, 1, 1); send(16'h4000, 1, 1);
        wait_idle();
        chk("mean_pos_0x28", int'(sample_out), 8'h28);
        for (int i = 0; i < NBLK; i++) send(16'hFF00, 1, 2);
        wait_idle();
        chk("mean_neg_0xFF", int'(sample_out), 8'hFF);
        for (int i = 0; i < NBLK; i++) send(16'h8000, 2, 1);
        wait_idle();
        chk("mean_min_0x80", int'(sample_out), 8'h80);
        send(16'h0400, 10, 1); send(16'h0800, 10, 2); send(16'h0C00, 10, 1); send(16'h1000, 10, 3);
        wait_idle();
        chk("held_strobe_mean", int'(sample_out), int'(floor_mean(16'h2800)));

        // Random blocks with random strobe shapes; some land inside the holdoff window.
        for (int b = 0; b < 40; b++) begin
            for (int i = 0; i < NBLK; i++)
                send(16'($urandom()), $urandom_range(1, 3), $urandom_range(1, 4));
        end
        wait_idle();
        chk("rand_dropped", int'(dropped_count), model_drop);
        chk("rand_sample_out", int'(sample_out), int'(last_mean));

        // One block every 20 cycles: most fall inside pulse+holdoff.
        for (int b = 0; b < 12; b++) begin
            for (int i = 0; i < NBLK; i++) send(16'($urandom()), 2, 3);
        end
        wait_idle();
        chk("rate_dropped", int'(dropped_count), model_drop);
        chk("rate_sample_out", int'(sample_out), int'(last_mean));

        // Flood until the drop counter must saturate.
        for (int b = 0; b < 340; b++) begin
            for (int i = 0; i < NBLK; i++) send(16'($urandom()), 1, 1);
        end
        wait_idle();
        chk("sat_model_255", model_drop, 255);
        chk("sat_dropped", int'(dropped_count), 255);
        chk("sat_sample_out", int'(sample_out), int'(last_mean));

        // Partial block then disable; strobes while disabled are ignored.
        send(16'h7000, 1, 1); send(16'h7000, 1, 1);
        enable = 1'b0;
        model_en = 1'b0;
        model_sum = 0;
        model_n = 0;
        send(16'h7FFF, 1, 1); send(16'h7FFF, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("disabled_irq", int'(interrupt_event), 0);
        chk("disabled_keeps_dropped", int'(dropped_count), 255);
        enable = 1'b1;
        model_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(16'hF000, 1, 1); send(16'hF000, 1, 1); send(16'hE000, 1, 1); send(16'hE000, 1, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("reenable_mean", int'(sample_out), 8'hE8);
        wait_idle();

        // Final block, then async reset in the middle of its pulse.
        send(16'h0100, 1, 1); send(16'h0200, 1, 1); send(16'h0300, 1, 1); send(16'h0400, 1, 1);
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            if (interrupt_event) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("pulse_before_reset", int'(seen), 1);
        chk("queue_drained", exp_q.size(), 0);
        rst_phase = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_irq", int'(interrupt_event), 0);
        chk("async_reset_sample_out", int'(sample_out), 0);
        chk("async_reset_dropped", int'(dropped_count), 0);
        chk("async_reset_busy", int'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
